// File: rtl/threshold_fifo.sv
// rtl/threshold_fifo.sv - synchronous FIFO with almost-full/empty thresholds and sticky error flags
// Define FIFO_FWFT_EN for first-word-fall-through output; default is registered read.
module threshold_fifo #(
   parameter int WIDTH         = 8,
   parameter int DEPTH         = 10,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           data_out,
   output logic                       empty,
   output logic                       full,
   output logic                       almost_empty,
   output logic                       almost_full,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       overflow,
   output logic                       underflow,
   input  logic                       clr_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   localparam logic [LW-1:0] AF_LVL   = LW'(AFULL_THRESH);
   localparam logic [LW-1:0] AE_LVL   = LW'(AEMPTY_THRESH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic [WIDTH-1:0] r_dout;
   logic             r_ovf;
   logic             r_unf;

   logic w_full;
   logic w_empty;
   logic w_wr_acc;
   logic w_rd_acc;
   logic w_pop;

   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   assign w_full   = (r_level == FULL_LVL);
   assign w_wr_acc = wr_en && !w_full;

`ifdef FIFO_FWFT_EN
   // r_level counts the output-stage word too, so the array holds level minus that word
   logic          r_valid;
   logic [LW-1:0] w_mem_cnt;
   logic          w_mem_ne;

   assign w_mem_cnt = r_level - {{(LW-1){1'b0}}, r_valid};
   assign w_mem_ne  = (w_mem_cnt != '0);
   assign w_empty   = !r_valid;
   assign w_rd_acc  = rd_en && r_valid;
   assign w_pop     = w_mem_ne && (!r_valid || w_rd_acc);
`else
   assign w_empty  = (r_level == '0);
   assign w_rd_acc = rd_en && !w_empty;
   assign w_pop    = w_rd_acc;
`endif

   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_dout   <= '0;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
`ifdef FIFO_FWFT_EN
         r_valid  <= 1'b0;
`endif
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= f_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= f_inc(r_rd_ptr);
         end
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
`ifdef FIFO_FWFT_EN
         if (w_pop) begin
            r_dout  <= r_mem[r_rd_ptr];
            r_valid <= 1'b1;
         end else if (w_rd_acc) begin
            r_valid <= 1'b0;
         end
`else
         if (w_rd_acc) begin
            r_dout <= r_mem[r_rd_ptr];
         end
`endif
         if (wr_en && w_full) begin
            r_ovf <= 1'b1;
         end else if (clr_err) begin
            r_ovf <= 1'b0;
         end
         // a read paired with a write into an empty FIFO is only deferred, not lost
         if (rd_en && w_empty && !wr_en) begin
            r_unf <= 1'b1;
         end else if (clr_err) begin
            r_unf <= 1'b0;
         end
      end
   end

   assign data_out     = r_dout;
   assign empty        = w_empty;
   assign full         = w_full;
   assign almost_empty = (r_level <= AE_LVL);
   assign almost_full  = (r_level >= AF_LVL);
   assign level        = r_level;
   assign overflow     = r_ovf;
   assign underflow    = r_unf;

endmodule
